fp_pack_norm: RTL

//  Post-normalize/pack stage of the FP adder; the inverse of the operand unpack/normalize step.

---
 rtl/fp_pack_norm_pkg.sv | 37 +++
 rtl/fp_round_rne.sv | 22 ++
 rtl/fp_pack_norm.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fp_pack_norm_pkg.sv
// Shared widths, field positions and encodings for the FP pack/normalize path.
// Also used by the operand unpack path and the rounding helper.
package fp_pack_norm_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 5;
    localparam int WORD_W   = 1 + EXP_W + MANT_W;
    localparam int ETMP_W   = EXP_W + 2;

    localparam int SIGN_BIT = WORD_W - 1;
    localparam int EXP_MSB  = WORD_W - 2;
    localparam int EXP_LSB  = MANT_W;
    localparam int MANT_MSB = MANT_W - 1;
    localparam int HID_BIT  = MANT_W - 2;
    localparam int G_BIT    = 2;
    localparam int R_BIT    = 1;
    localparam int S_BIT    = 0;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

    // Classification decided during normalization, consumed by the round/pack step.
    typedef enum logic [1:0] {
        K_NORMAL,
        K_SUB,
        K_ZERO,
        K_SPEC
    } kind_e;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on the internal mantissa {carry, hidden, frac, G, R, S}.
// Returns the rounded upper bits m[27:3], the carry into m[27], and the inexact indication.
module fp_round_rne
    import fp_pack_norm_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    output logic [MANT_W-4:0] mant_o,
    output logic              carry_o,
    output logic              inexact_o
);

    logic up;

    always_comb begin
        inexact_o = |mant_i[G_BIT:S_BIT];
        // Ties go to the even result: only round up on a tie when the LSB is odd.
        up        = mant_i[G_BIT] & (mant_i[R_BIT] | mant_i[S_BIT] | mant_i[3]);
        mant_o    = mant_i[MANT_MSB:3] + {{(MANT_W-4){1'b0}}, up};
        carry_o   = mant_o[MANT_W-4];
    end

endmodule

// File: rtl/fp_pack_norm.sv
// Post-normalize, RNE round and IEEE-754 single pack for the FP adder sum word.
// One operation in flight; normalization shifts one bit per cycle.
module fp_pack_norm
    import fp_pack_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [2:0]        out_flags
);

    localparam logic signed [ETMP_W-1:0] E_ONE = ETMP_W'(1);
    localparam logic signed [ETMP_W-1:0] E_INF = {2'b00, EXP_MAX};

    state_e                    state_q, state_d;
    kind_e                     kind_q, kind_d;
    logic                      sign_q, sign_d;
    logic signed [ETMP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0]         mant_q, mant_d;
    logic                      unf_q, unf_d;
    logic [31:0]               out_data_q, out_data_d;
    logic [2:0]                out_flags_q, out_flags_d;

    logic [MANT_W-4:0]         rnd_mant;
    logic                      rnd_carry;
    logic                      rnd_inexact;
    logic signed [ETMP_W-1:0]  exp_r;

    fp_round_rne u_round (
        .mant_i    (mant_q),
        .mant_o    (rnd_mant),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= K_NORMAL;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            unf_q       <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            unf_q       <= unf_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        unf_d       = unf_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        exp_r       = exp_q + (rnd_carry ? E_ONE : '0);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[SIGN_BIT];
                    exp_d   = {2'b00, in_data[EXP_MSB:EXP_LSB]};
                    mant_d  = in_data[MANT_MSB:0];
                    unf_d   = 1'b0;
                    // Special-ness is a property of the incoming exponent, not of one reached by shifting.
                    kind_d  = (in_data[EXP_MSB:EXP_LSB] == EXP_MAX) ? K_SPEC : K_NORMAL;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (kind_q == K_SPEC) begin
                    state_d = ST_ROUND;
                end else if (mant_q == '0) begin
                    kind_d  = K_ZERO;
                    state_d = ST_ROUND;
                end else if (mant_q[MANT_MSB]) begin
                    mant_d = {1'b0, mant_q[MANT_MSB:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + E_ONE;
                end else if (!mant_q[HID_BIT] && (exp_q > E_ONE)) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - E_ONE;
                end else if (!mant_q[HID_BIT]) begin
                    kind_d  = K_SUB;
                    unf_d   = |mant_q[G_BIT:S_BIT];
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = ST_DONE;
                case (kind_q)
                    K_SPEC: begin
                        out_data_d  = {sign_q, EXP_MAX, |mant_q[HID_BIT-1:3], {(FRAC_W-1){1'b0}}};
                        out_flags_d = 3'b000;
                    end
                    K_ZERO: begin
                        out_data_d  = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                        out_flags_d = 3'b000;
                    end
                    K_SUB: begin
                        // Rounding may carry into the hidden bit, promoting the result to the smallest normal.
                        out_data_d  = {sign_q, {(EXP_W-1){1'b0}}, rnd_mant[FRAC_W], rnd_mant[FRAC_W-1:0]};
                        out_flags_d = {1'b0, unf_q, rnd_inexact};
                    end
                    default: begin
                        if (exp_r >= E_INF) begin
                            out_data_d  = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                            out_flags_d = 3'b101;
                        end else begin
                            out_data_d  = {sign_q, exp_r[EXP_W-1:0],
                                           rnd_carry ? rnd_mant[FRAC_W:1] : rnd_mant[FRAC_W-1:0]};
                            out_flags_d = {2'b00, rnd_inexact};
                        end
                    end
                endcase
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule
